multicycle_ctrl: RTL and testbench

// Moore-style sequencer that drives the shared-memory MIPS datapath over several cycles per instruction.
// One memory port serves both fetch and load/store.

---
 rtl/multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the shared-memory multicycle MIPS datapath, with memory wait/timeout handling.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
`ifdef MULTICYCLE_CTRL_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_retired,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
    , output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_retired
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t        cur;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout;
    logic          legal_op;

    // funct only matters to the ALU decoder downstream of alu_op=10
    logic unused_funct;
    assign unused_funct = ^funct;

    always_comb begin
        waiting  = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR)) && !mem_ready;
        timeout  = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == CW'(TO_LAST));
        legal_op = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                   (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (waiting && !timeout) ? wait_cnt + 1'b1 : '0;
            case (cur)
                FETCH:   cur <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYPE:     cur <= EXEC;
                        OP_BEQ:       cur <= BRANCH;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR:  cur <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   cur <= mem_ready ? MEMWB : (timeout ? FETCH : MEMRD);
                MEMWR:   cur <= (mem_ready || timeout) ? FETCH : MEMWR;
                EXEC:    cur <= ALUWB;
                ADDIEX:  cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    // Outputs decode the current state; everything is forced low while reset is held
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        bus_error     = 1'b0;
        state         = reset ? 4'd0 : cur;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    bus_error = timeout;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = !legal_op;
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read  = 1'b1;
                    iord      = 1'b1;
                    bus_error = timeout;
                end
                MEMWB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = 1'b1;
                    instr_retired = 1'b1;
                end
                MEMWR: begin
                    mem_write     = 1'b1;
                    iord          = 1'b1;
                    instr_retired = mem_ready;
                    bus_error     = timeout;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALUWB: begin
                    reg_write     = 1'b1;
                    reg_dst       = 1'b1;
                    instr_retired = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_src        = 2'b01;
                    pc_write      = zero;
                    instr_retired = 1'b1;
                end
                ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDIWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                JUMP: begin
                    pc_src        = 2'b10;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else begin
            perf_cycles  <= perf_cycles + 1'b1;
            perf_retired <= perf_retired + PERF_W'(instr_retired);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl, built with MEM_TIMEOUT=4.
// Covers the instruction state traces, wait states, timeout, illegal opcodes and mid-instruction reset.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write;
    logic       instr_retired, illegal, bus_error;
    logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    int total = 0;
    int bad = 0;
    int retireCount = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .instr_retired(instr_retired), .illegal(illegal),
        .bus_error(bus_error), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic z);
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    // Runs one instruction with mem_ready=1, checking the state trace and the single retire pulse
    task automatic runInstr(input string name, input logic [5:0] op, input logic z,
                            input int n, input int exp [5]);
        for (int i = 0; i < n; i++) begin
            applyStimulus(op, 1'b1, z);
            checkOutput($sformatf("%s state%0d", name, i), 32'(state), 32'(exp[i]));
            checkOutput($sformatf("%s retire%0d", name, i), 32'(instr_retired), 32'(i == n - 1));
            if (exp[i] == 0)
                checkOutput($sformatf("%s ir_write", name), 32'(ir_write), 32'd1);
            if (exp[i] == 8) begin
                checkOutput($sformatf("%s beq pc_write", name), 32'(pc_write), 32'(z));
                checkOutput($sformatf("%s beq pc_src", name), 32'(pc_src), 32'd1);
            end
            retireCount += int'(instr_retired);
            nextCycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        funct = 6'b100000;
        applyStimulus(6'b000000, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset ir_write", 32'(ir_write), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        checkOutput("reset perf_cycles", perf_cycles, 32'd0);
        checkOutput("reset perf_retired", perf_retired, 32'd0);
`endif
        reset = 1'b0;

        runInstr("addi", 6'b001000, 1'b0, 4, '{0, 1, 9, 10, 0});
        runInstr("radd", 6'b000000, 1'b0, 4, '{0, 1, 6, 7, 0});
        runInstr("sw",   6'b101011, 1'b0, 4, '{0, 1, 2, 5, 0});
        runInstr("lw",   6'b100011, 1'b0, 5, '{0, 1, 2, 3, 4});
        runInstr("beq1", 6'b000100, 1'b1, 3, '{0, 1, 8, 0, 0});
        runInstr("j",    6'b000010, 1'b0, 3, '{0, 1, 11, 0, 0});
        checkOutput("retire total", 32'(retireCount), 32'd6);
        runInstr("beq0", 6'b000100, 1'b0, 3, '{0, 1, 8, 0, 0});

        // lw with three wait cycles in MEMRD
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b100011, 1'b1, 1'b0);
            checkOutput("lwwait pre", 32'(state), 32'(i));
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'b100011, i == 3, 1'b0);
            checkOutput("lwwait state", 32'(state), 32'd3);
            checkOutput("lwwait rd_iord", 32'({mem_read, iord, bus_error}), 32'b110);
            nextCycle();
        end
        applyStimulus(6'b100011, 1'b1, 1'b0);
        checkOutput("lwwait memwb", 32'(state), 32'd4);
        checkOutput("lwwait wb", 32'({reg_write, mem_to_reg, reg_dst, instr_retired}), 32'b1101);
        nextCycle();
        checkOutput("lwwait back", 32'(state), 32'd0);

        // Fetch timeout: bus_error on the 4th wait cycle, then retry from FETCH
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'b000000, 1'b0, 1'b0);
            checkOutput("fetchto state", 32'(state), 32'd0);
            checkOutput("fetchto bus_error", 32'(bus_error), 32'(i == 3));
            checkOutput("fetchto ir_write", 32'({ir_write, pc_write}), 32'd0);
            nextCycle();
        end
        applyStimulus(6'b000000, 1'b0, 1'b0);
        checkOutput("fetchto after", 32'({state, bus_error}), 32'd0);
        nextCycle();

        // Illegal opcode in DECODE
        applyStimulus(6'b111111, 1'b1, 1'b0);
        checkOutput("illegal fetch", 32'(state), 32'd0);
        nextCycle();
        applyStimulus(6'b111111, 1'b1, 1'b0);
        checkOutput("illegal decode", 32'(state), 32'd1);
        checkOutput("illegal pulse", 32'({illegal, reg_write, mem_write, instr_retired}), 32'b1000);
        nextCycle();
        checkOutput("illegal back", 32'({state, illegal}), 32'd0);

        // Reset while MEMWR is stalled
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b101011, 1'b1, 1'b0);
            nextCycle();
        end
        applyStimulus(6'b101011, 1'b0, 1'b0);
        checkOutput("rstmw memwr", 32'({state, mem_write}), 32'b01011);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("rstmw held", 32'({state, mem_write, instr_retired}), 32'd0);
        nextCycle();
        checkOutput("rstmw after", 32'({state, mem_write, instr_retired}), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        checkOutput("rstmw perf_cycles", perf_cycles, 32'd0);
        checkOutput("rstmw perf_retired", perf_retired, 32'd0);
`endif
        reset = 1'b0;
        applyStimulus(6'b000000, 1'b1, 1'b0);
        checkOutput("rstmw fetch", 32'({state, mem_read}), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
